toy_rename_freelist: RTL and testbench
======================================

TOY_RENAME_FREELIST -- requirements
Module: toy_rename_freelist

Interface
REQ-001 The block SHALL have parameter PHY_REG_NUM, default 64, meaning total physical registers.
REQ-002 The block SHALL have parameter ARCH_REG_NUM, default 32, meaning architectural registers (FL_DEPTH = PHY_REG_NUM-ARCH_REG_NUM = 32 free-list slots).
REQ-003 The block SHALL have parameter LANE_NUM, default 4, meaning allocate/release/commit lanes per cycle (equals INST_DECODE_NUM).
REQ-004 The block SHALL have ports, one per line:
 clk  input  1  clock, all state on rising edge;
 rst_n  input  1  reset, asynchronous, active-low;
 alloc_req  input  LANE_NUM  per-lane request for a new physical rd id;
 alloc_id  output  LANE_NUM x PHY_REG_ID_WIDTH  per-lane allocated id;
 alloc_ready  output  1  free list can serve any request pattern this cycle;
 rel_en  input  LANE_NUM  per-lane release of a retired old physical id;
 rel_id  input  LANE_NUM x PHY_REG_ID_WIDTH  ids being released;
 commit_num  input  3  number of allocations (0..LANE_NUM) committed this cycle, oldest first;
 cancel_edge_en  input  1  flush, restore speculative state to committed state;
 free_cnt  output  6  speculative free-entry count.

Function
REQ-005 Storage SHALL be a circular buffer of FL_DEPTH entries, PHY_REG_ID_WIDTH bits each, with 5-bit indices head, commit_head, tail, all wrapping modulo FL_DEPTH.
REQ-006 Counters spec_cnt and commit_cnt SHALL be 6 bits, range 0..FL_DEPTH; free_cnt SHALL equal spec_cnt.
REQ-007 alloc_ready SHALL be 1 iff spec_cnt >= LANE_NUM (all-or-nothing; partial service forbidden).
REQ-008 alloc_id SHALL be combinational from current state: the k-th set bit of alloc_req (counting from lane 0) SHALL receive entry[head+k]; lanes with alloc_req=0 SHALL output entry[head] and are don't-care.
REQ-009 An allocation fires when alloc_ready=1 and cancel_edge_en=0; then head advances by n=popcount(alloc_req) and spec_cnt decreases by n at the next edge.
REQ-010 alloc_req with alloc_ready=0 SHALL leave head and spec_cnt unchanged by allocation.
REQ-011 Release: the j-th set bit of rel_en SHALL write rel_id of that lane to entry[tail+j]; tail advances by r=popcount(rel_en); spec_cnt and commit_cnt each increase by r; released ids become allocatable the next cycle, never in the same cycle.
REQ-012 Commit: commit_head advances by commit_num and commit_cnt decreases by commit_num each edge.
REQ-013 Simultaneous alloc, release and commit in one cycle SHALL all apply: spec_cnt_next = spec_cnt - n + r; commit_cnt_next = commit_cnt - commit_num + r.
REQ-014 cancel_edge_en=1 SHALL override allocation: head <= commit_head + commit_num; spec_cnt <= commit_cnt - commit_num + r; same-cycle release and commit still apply.
REQ-015 Entries between tail and head are never read or rewritten except by release; contents persist across cancel.
REQ-016 Overflow (spec_cnt_next > FL_DEPTH), commit_num > LANE_NUM, or commit beyond head SHALL be flagged by simulation assertions; RTL behaviour is then undefined.

Reset
REQ-017 On rst_n low, asynchronously: entry[i] = ARCH_REG_NUM+i for i=0..FL_DEPTH-1; head = commit_head = tail = 0; spec_cnt = commit_cnt = FL_DEPTH.
REQ-018 After reset, free_cnt = 32, alloc_ready = 1, alloc_id lane k = 32 for the lowest requesting lane.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight state with no partial update on the deasserting edge.

Verification
REQ-020 Post-reset alloc_req=4'b1111 -> alloc_id = {35,34,33,32} (lane3..lane0); next cycle free_cnt=28.
REQ-021 alloc_req=4'b1010 from reset -> lane1=32, lane3=33; next free_cnt=30, subsequent 4'b0001 -> lane0=34.
REQ-022 Allocate 29 ids with no release -> free_cnt=3, alloc_ready=0; alloc_req=4'b1111 held -> no state change; rel_en=4'b0001 rel_id=5 -> next cycle free_cnt=4, alloc_ready=1, id 5 allocated last after 61,62,63.
REQ-023 Allocate 8 (ids 32..39), commit_num=2, then cancel_edge_en=1 with commit_num=1 -> next cycle free_cnt=29, next allocation returns 35.
REQ-024 Same cycle: alloc 4'b1111, rel_en=4'b0011 (ids 1,2), commit_num=4 at spec_cnt=8 -> spec_cnt_next=6, commit_cnt_next per REQ-013, tail advanced by 2.
REQ-025 Steady alloc 4/cycle with release 4/cycle for 20 cycles -> head and tail wrap past index 31 without id loss or duplication (scoreboard: every id 0..63 owned exactly once by mapping table or free list).

Source files
------------

// File: rtl/toy_rename_freelist.sv
// Rename free list: circular buffer of free physical register ids with a
// speculative head for allocation and a committed head for flush recovery.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   alloc_req       per-lane request for a new physical id
//   alloc_id        per-lane allocated id (k-th requester gets entry[head+k])
//   alloc_ready     at least LANE_NUM free entries, so any pattern is served
//   rel_en, rel_id  per-lane release of retired old physical ids
//   commit_num      number of oldest allocations committed this cycle
//   cancel_edge_en  flush: rewind head and spec count to the committed view
//   free_cnt        speculative free-entry count
module toy_rename_freelist #(
    parameter int PHY_REG_NUM  = 64,
    parameter int ARCH_REG_NUM = 32,
    parameter int LANE_NUM     = 4,
    localparam int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [LANE_NUM-1:0]                       alloc_req,
    output logic [LANE_NUM-1:0][PHY_REG_ID_WIDTH-1:0] alloc_id,
    output logic                                      alloc_ready,
    input  logic [LANE_NUM-1:0]                       rel_en,
    input  logic [LANE_NUM-1:0][PHY_REG_ID_WIDTH-1:0] rel_id,
    input  logic [2:0]                                commit_num,
    input  logic                                      cancel_edge_en,
    output logic [5:0]                                free_cnt
);

    localparam int FL_DEPTH = PHY_REG_NUM - ARCH_REG_NUM;

    typedef logic [PHY_REG_ID_WIDTH-1:0] id_t;

    id_t        entry_q [FL_DEPTH];
    id_t        entry_d [FL_DEPTH];
    logic [4:0] head_q, head_d;
    logic [4:0] commit_head_q, commit_head_d;
    logic [4:0] tail_q, tail_d;
    logic [5:0] spec_cnt_q, spec_cnt_d;
    logic [5:0] commit_cnt_q, commit_cnt_d;

    logic [2:0] alloc_n;
    logic [2:0] rel_n;
    logic [2:0] alloc_eff;
    logic       alloc_fire;

    // Index advance modulo FL_DEPTH; offsets never exceed LANE_NUM.
    function automatic logic [4:0] idx_add(input logic [4:0] idx,
                                           input logic [2:0] off);
        logic [5:0] s;
        s = {1'b0, idx} + {3'b0, off};
        if (s >= 6'(FL_DEPTH)) begin
            s = s - 6'(FL_DEPTH);
        end
        return s[4:0];
    endfunction

    assign alloc_ready = (spec_cnt_q >= 6'(LANE_NUM));
    assign free_cnt    = spec_cnt_q;
    assign alloc_fire  = alloc_ready && !cancel_edge_en;
    assign alloc_eff   = alloc_fire ? alloc_n : 3'd0;

    // Requesting lanes are packed onto consecutive entries from head.
    always_comb begin
        alloc_n = 3'd0;
        for (int l = 0; l < LANE_NUM; l++) begin
            alloc_id[l] = entry_q[head_q];
            if (alloc_req[l]) begin
                alloc_id[l] = entry_q[idx_add(head_q, alloc_n)];
                alloc_n     = alloc_n + 3'd1;
            end
        end
    end

    // Released ids are packed onto consecutive entries from tail. They are
    // only visible to allocation after the edge since alloc reads entry_q.
    always_comb begin
        rel_n = 3'd0;
        for (int i = 0; i < FL_DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end
        for (int l = 0; l < LANE_NUM; l++) begin
            if (rel_en[l]) begin
                entry_d[idx_add(tail_q, rel_n)] = rel_id[l];
                rel_n = rel_n + 3'd1;
            end
        end
    end

    always_comb begin
        tail_d        = idx_add(tail_q, rel_n);
        commit_head_d = idx_add(commit_head_q, commit_num);
        commit_cnt_d  = commit_cnt_q - {3'b0, commit_num} + {3'b0, rel_n};
        head_d        = idx_add(head_q, alloc_eff);
        spec_cnt_d    = spec_cnt_q - {3'b0, alloc_eff} + {3'b0, rel_n};
        // A flush rewinds to the committed view including this cycle's
        // commits and releases; any same-cycle allocation is dropped.
        if (cancel_edge_en) begin
            head_d     = commit_head_d;
            spec_cnt_d = commit_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entry_q[i] <= id_t'(ARCH_REG_NUM + i);
            end
            head_q        <= '0;
            commit_head_q <= '0;
            tail_q        <= '0;
            spec_cnt_q    <= 6'(FL_DEPTH);
            commit_cnt_q  <= 6'(FL_DEPTH);
        end else begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            head_q        <= head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            spec_cnt_q    <= spec_cnt_d;
            commit_cnt_q  <= commit_cnt_d;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n)
        spec_cnt_d <= 6'(FL_DEPTH)
    ) else $error("free list spec count overflow");

    a_commit_num : assert property (
        @(posedge clk) disable iff (!rst_n)
        commit_num <= 3'(LANE_NUM)
    ) else $error("commit_num above lane count");

    // Uncommitted allocations are exactly commit_cnt - spec_cnt.
    a_commit_head : assert property (
        @(posedge clk) disable iff (!rst_n)
        {3'b0, commit_num} <= (commit_cnt_q - spec_cnt_q)
    ) else $error("commit beyond allocation head");
`endif

endmodule

// File: tb/tb_toy_rename_freelist.sv
// Directed bench for toy_rename_freelist: reset state, packing, stall,
// cancel, combined update and a wrap-around ownership scoreboard.
module tb_toy_rename_freelist;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      alloc_req;
    logic [3:0][5:0] alloc_id;
    logic            alloc_ready;
    logic [3:0]      rel_en;
    logic [3:0][5:0] rel_id;
    logic [2:0]      commit_num;
    logic            cancel_edge_en;
    logic [5:0]      free_cnt;

    int n_chk = 0;
    int n_bad = 0;

    int q[$];
    int map_t[32];
    int olds_prev[4];
    int olds_cur[4];
    bit seen[64];
    bit have_prev;

    always #5 clk = ~clk;

    toy_rename_freelist dut (
        .clk(clk),
        .rst_n(rst_n),
        .alloc_req(alloc_req),
        .alloc_id(alloc_id),
        .alloc_ready(alloc_ready),
        .rel_en(rel_en),
        .rel_id(rel_id),
        .commit_num(commit_num),
        .cancel_edge_en(cancel_edge_en),
        .free_cnt(free_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alloc_req      = '0;
        rel_en         = '0;
        rel_id         = '0;
        commit_num     = '0;
        cancel_edge_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        do_reset();

        // reset state
        chk("rst free", int'(free_cnt), 32);
        chk("rst ready", int'(alloc_ready), 1);
        chk("rst id0", int'(alloc_id[0]), 32);

        // full-width allocation
        alloc_req = 4'b1111;
        #1;
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("a4 l%0d", l), int'(alloc_id[l]), 32 + l);
        end
        tick();
        alloc_req = '0;
        chk("a4 free", int'(free_cnt), 28);

        // sparse packing
        do_reset();
        alloc_req = 4'b1010;
        #1;
        chk("sp l1", int'(alloc_id[1]), 32);
        chk("sp l3", int'(alloc_id[3]), 33);
        tick();
        alloc_req = '0;
        chk("sp free", int'(free_cnt), 30);
        alloc_req = 4'b0001;
        #1;
        chk("sp l0", int'(alloc_id[0]), 34);
        tick();
        alloc_req = '0;

        // asynchronous reset mid-operation
        rst_n = 1'b0;
        #2;
        chk("async free", int'(free_cnt), 32);
        chk("async id0", int'(alloc_id[0]), 32);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post rst free", int'(free_cnt), 32);

        // exhaustion stall and release
        alloc_req = 4'b1111;
        for (int c = 0; c < 7; c++) tick();
        alloc_req = 4'b0001;
        tick();
        chk("ex free", int'(free_cnt), 3);
        chk("ex ready", int'(alloc_ready), 0);
        alloc_req = 4'b1111;
        tick();
        chk("hold free", int'(free_cnt), 3);
        chk("hold id0", int'(alloc_id[0]), 61);
        alloc_req = '0;
        rel_en = 4'b0001;
        rel_id[0] = 6'd5;
        #1;
        chk("rel same cyc", int'(alloc_ready), 0);
        tick();
        idle();
        chk("rel free", int'(free_cnt), 4);
        chk("rel ready", int'(alloc_ready), 1);
        alloc_req = 4'b1111;
        #1;
        chk("rel l0", int'(alloc_id[0]), 61);
        chk("rel l1", int'(alloc_id[1]), 62);
        chk("rel l2", int'(alloc_id[2]), 63);
        chk("rel l3", int'(alloc_id[3]), 5);
        tick();
        idle();
        chk("rel drain", int'(free_cnt), 0);

        // cancel restores committed view
        do_reset();
        alloc_req = 4'b1111;
        tick();
        tick();
        alloc_req = '0;
        commit_num = 3'd2;
        tick();
        chk("cc free", int'(free_cnt), 24);
        alloc_req = 4'b1111;
        commit_num = 3'd1;
        cancel_edge_en = 1'b1;
        tick();
        idle();
        chk("cancel free", int'(free_cnt), 29);
        alloc_req = 4'b0001;
        #1;
        chk("cancel id", int'(alloc_id[0]), 35);
        alloc_req = '0;

        // simultaneous alloc, release and commit
        do_reset();
        alloc_req = 4'b1111;
        for (int c = 0; c < 6; c++) tick();
        chk("sim pre", int'(free_cnt), 8);
        rel_en = 4'b0011;
        rel_id[0] = 6'd1;
        rel_id[1] = 6'd2;
        commit_num = 3'd4;
        tick();
        idle();
        chk("sim spec", int'(free_cnt), 6);
        cancel_edge_en = 1'b1;
        tick();
        idle();
        chk("sim commit", int'(free_cnt), 30);
        alloc_req = 4'b1111;
        for (int c = 0; c < 7; c++) tick();
        alloc_req = 4'b0011;
        #1;
        chk("sim t0", int'(alloc_id[0]), 1);
        chk("sim t1", int'(alloc_id[1]), 2);
        idle();
        rel_en = 4'b0001;
        rel_id[0] = 6'd9;
        tick();
        rel_id[0] = 6'd10;
        tick();
        idle();
        chk("sim rfree", int'(free_cnt), 4);
        alloc_req = 4'b1111;
        #1;
        chk("sim a0", int'(alloc_id[0]), 1);
        chk("sim a1", int'(alloc_id[1]), 2);
        chk("sim a2", int'(alloc_id[2]), 9);
        chk("sim a3", int'(alloc_id[3]), 10);
        tick();
        idle();

        // steady state wrap with ownership scoreboard
        do_reset();
        q.delete();
        for (int i = 32; i < 64; i++) q.push_back(i);
        for (int a = 0; a < 32; a++) map_t[a] = a;
        have_prev = 1'b0;
        for (int c = 0; c < 20; c++) begin
            alloc_req = 4'b1111;
            commit_num = have_prev ? 3'd4 : 3'd0;
            rel_en = have_prev ? 4'b1111 : 4'b0000;
            for (int l = 0; l < 4; l++) rel_id[l] = 6'(olds_prev[l]);
            #1;
            for (int l = 0; l < 4; l++) begin
                int e;
                int a;
                e = q.pop_front();
                chk($sformatf("wrap c%0d l%0d", c, l), int'(alloc_id[l]), e);
                a = (c * 4 + l) % 32;
                olds_cur[l] = map_t[a];
                map_t[a] = e;
            end
            tick();
            if (have_prev) begin
                for (int l = 0; l < 4; l++) q.push_back(olds_prev[l]);
            end
            olds_prev = olds_cur;
            have_prev = 1'b1;
        end
        idle();
        commit_num = 3'd4;
        rel_en = 4'b1111;
        for (int l = 0; l < 4; l++) rel_id[l] = 6'(olds_prev[l]);
        tick();
        for (int l = 0; l < 4; l++) q.push_back(olds_prev[l]);
        idle();
        chk("wrap free", int'(free_cnt), 32);
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            alloc_req = 4'b1111;
            #1;
            for (int l = 0; l < 4; l++) begin
                int e;
                e = q.pop_front();
                chk($sformatf("drain c%0d l%0d", c, l),
                    int'(alloc_id[l]), e);
                seen[alloc_id[l]] = 1'b1;
            end
            tick();
        end
        idle();
        for (int a = 0; a < 32; a++) seen[map_t[a]] = 1'b1;
        begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < 64; i++) cnt += int'(seen[i]);
            chk("own", cnt, 64);
        end
        chk("drain free", int'(free_cnt), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
